// File: rtl/router_fifo_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | router_fifo_if : write/read/flush bundle between the register stage,        |
// |                  a router_fifo and its destination port.                    |
// | Revision       : 1.0                                                        |
// +-----------------------------------------------------------------------------+
interface router_fifo_if #(
  parameter int WIDTH = 8
);
  logic             soft_reset;
  logic             write_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic             read_enb;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  modport master (
    output soft_reset, write_enb, lfd_state, data_in, read_enb,
    input  data_out, full, empty
  );

  modport slave (
    input  soft_reset, write_enb, lfd_state, data_in, read_enb,
    output data_out, full, empty
  );
endinterface
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | router_fifo : per-port output buffer of the 1x3 router. Stores bytes with a |
// |               header marker and streams one packet at a time, idling the    |
// |               output between packets. Option: ROUTER_FIFO_TRISTATE_EN       |
// |               (idle value is all-z instead of all-zero).                    |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module router_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic         clock,
  input  logic         reset,
  router_fifo_if.slave bus
);

`ifdef ROUTER_FIFO_TRISTATE_EN
  localparam logic [WIDTH-1:0] IDLE_VALUE = {WIDTH{1'bz}};
`else
  localparam logic [WIDTH-1:0] IDLE_VALUE = {WIDTH{1'b0}};
`endif

  logic [WIDTH:0]  mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [5:0]      pkt_cnt;
  logic [WIDTH:0]  rd_word;
  logic            do_wr;
  logic            do_rd;

  assign bus.empty = (wr_ptr == rd_ptr);
  assign bus.full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // soft_reset wins over both sides in the cycle it is asserted
  assign do_wr   = bus.write_enb && !bus.full  && !bus.soft_reset;
  assign do_rd   = bus.read_enb  && !bus.empty && !bus.soft_reset;
  assign rd_word = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pkt_cnt      <= '0;
      bus.data_out <= IDLE_VALUE;
    end else if (bus.soft_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pkt_cnt      <= '0;
      bus.data_out <= IDLE_VALUE;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        bus.data_out <= rd_word[WIDTH-1:0];
        rd_ptr       <= rd_ptr + 1'b1;
        // header byte carries payload length in its upper six bits; +1 for parity
        if (rd_word[WIDTH]) begin
          pkt_cnt <= rd_word[WIDTH-1:WIDTH-6] + 6'd1;
        end else if (pkt_cnt != 6'd0) begin
          pkt_cnt <= pkt_cnt - 6'd1;
        end
      end else if (pkt_cnt == 6'd0) begin
        bus.data_out <= IDLE_VALUE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_router_fifo : directed self-checking bench for router_fifo.              |
// | Revision       : 1.0                                                        |
// +-----------------------------------------------------------------------------+
module tb_router_fifo;

`ifdef ROUTER_FIFO_TRISTATE_EN
  localparam logic [7:0] IDLE = 8'hzz;
`else
  localparam logic [7:0] IDLE = 8'h00;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  router_fifo_if #(.WIDTH(8)) bus ();

  router_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = 8'h00;
    bus.read_enb   = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic lfd);
    bus.write_enb = 1'b1;
    bus.lfd_state = lfd;
    bus.data_in   = d;
    tick();
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    checks++;
    if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++;
    if (bus.data_out !== IDLE) begin errors++; $display("FAIL reset_data: got %h want %h", bus.data_out, IDLE); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_packet();
    logic [7:0] pkt [5];
    pkt[0] = 8'h0E; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33;
    pkt[4] = 8'h0E ^ 8'h11 ^ 8'h22 ^ 8'h33;
    for (int i = 0; i < 5; i++) write_byte(pkt[i], i == 0);
    bus.read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.data_out !== pkt[i]) begin
        errors++; $display("FAIL packet_byte%0d: got %h want %h", i, bus.data_out, pkt[i]);
      end
    end
    bus.read_enb = 1'b0;
    tick();
    checks++;
    if (bus.data_out !== IDLE) begin errors++; $display("FAIL packet_idle: got %h want %h", bus.data_out, IDLE); end
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL packet_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) write_byte(8'h40 + 8'(i), 1'b0);
    checks++;
    if (bus.full !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", bus.full); end
    write_byte(8'hEE, 1'b0);
    checks++;
    if (bus.full !== 1'b1) begin errors++; $display("FAIL full_after_drop: got %b want 1", bus.full); end
    bus.read_enb = 1'b1;
    tick();
    bus.read_enb = 1'b0;
    checks++;
    if (bus.full !== 1'b0) begin errors++; $display("FAIL full_clear: got %b want 0", bus.full); end
    checks++;
    if (bus.data_out !== 8'h40) begin errors++; $display("FAIL full_byte0: got %h want 40", bus.data_out); end
    bus.read_enb = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++;
      if (bus.data_out !== 8'h40 + 8'(i)) begin
        errors++; $display("FAIL full_byte%0d: got %h want %h", i, bus.data_out, 8'h40 + 8'(i));
      end
    end
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_drained: got %b want 1", bus.empty); end
    tick();
    bus.read_enb = 1'b0;
    checks++;
    if (bus.data_out !== IDLE) begin errors++; $display("FAIL full_no17th: got %h want %h", bus.data_out, IDLE); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) write_byte(8'h80 + 8'(i), 1'b0);
    bus.read_enb  = 1'b1;
    bus.write_enb = 1'b1;
    bus.data_in   = 8'hAA;
    tick();
    bus.write_enb = 1'b0;
    checks++;
    if (bus.data_out !== 8'h80) begin errors++; $display("FAIL simfull_read: got %h want 80", bus.data_out); end
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++;
      if (bus.data_out !== 8'h80 + 8'(i)) begin
        errors++; $display("FAIL simfull_byte%0d: got %h want %h", i, bus.data_out, 8'h80 + 8'(i));
      end
    end
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL simfull_write_dropped: empty got %b want 1", bus.empty); end
    bus.write_enb = 1'b1;
    bus.data_in   = 8'h55;
    tick();
    bus.write_enb = 1'b0;
    checks++;
    if (bus.empty !== 1'b0) begin errors++; $display("FAIL simempty_empty: got %b want 0", bus.empty); end
    checks++;
    if (bus.data_out !== IDLE) begin errors++; $display("FAIL simempty_data: got %h want %h", bus.data_out, IDLE); end
    tick();
    bus.read_enb = 1'b0;
    checks++;
    if (bus.data_out !== 8'h55) begin errors++; $display("FAIL simempty_readback: got %h want 55", bus.data_out); end
    tick();
  endtask

  task automatic test_soft_reset();
    logic [7:0] pkt [3];
    write_byte(8'h0C, 1'b1);
    write_byte(8'hA1, 1'b0);
    write_byte(8'hB2, 1'b0);
    write_byte(8'hC3, 1'b0);
    write_byte(8'h0C ^ 8'hA1 ^ 8'hB2 ^ 8'hC3, 1'b0);
    bus.read_enb = 1'b1;
    tick();
    tick();
    bus.read_enb = 1'b0;
    tick();
    checks++;
    if (bus.data_out !== 8'hA1) begin errors++; $display("FAIL soft_hold: got %h want a1", bus.data_out); end
    bus.soft_reset = 1'b1;
    bus.read_enb   = 1'b1;
    bus.write_enb  = 1'b1;
    bus.data_in    = 8'h77;
    tick();
    idle_inputs();
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL soft_empty: got %b want 1", bus.empty); end
    checks++;
    if (bus.data_out !== IDLE) begin errors++; $display("FAIL soft_data: got %h want %h", bus.data_out, IDLE); end
    checks++;
    if (dut.pkt_cnt !== 6'd0) begin errors++; $display("FAIL soft_pkt_cnt: got %0d want 0", dut.pkt_cnt); end
    pkt[0] = 8'h04; pkt[1] = 8'hD1; pkt[2] = 8'h04 ^ 8'hD1;
    for (int i = 0; i < 3; i++) write_byte(pkt[i], i == 0);
    bus.read_enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.data_out !== pkt[i]) begin
        errors++; $display("FAIL soft_newpkt%0d: got %h want %h", i, bus.data_out, pkt[i]);
      end
    end
    bus.read_enb = 1'b0;
    tick();
    checks++;
    if (bus.data_out !== IDLE) begin errors++; $display("FAIL soft_newidle: got %h want %h", bus.data_out, IDLE); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pkt [7];
    logic       lfd [7];
    pkt[0] = 8'h04; pkt[1] = 8'h10; pkt[2] = 8'h14;
    pkt[3] = 8'h08; pkt[4] = 8'h20; pkt[5] = 8'h30; pkt[6] = 8'h18;
    for (int i = 0; i < 7; i++) lfd[i] = (i == 0) || (i == 3);
    for (int i = 0; i < 7; i++) write_byte(pkt[i], lfd[i]);
    bus.read_enb = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (bus.data_out !== pkt[i]) begin
        errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, bus.data_out, pkt[i]);
      end
    end
    bus.read_enb = 1'b0;
    tick();
    checks++;
    if (bus.data_out !== IDLE) begin errors++; $display("FAIL b2b_idle: got %h want %h", bus.data_out, IDLE); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle_inputs();
    test_reset();
    test_packet();
    test_full();
    test_simultaneous();
    test_soft_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
